// File: rtl/rom_download_arbiter_if.sv
`timescale 1ns/1ps
// External 16-bit ROM memory port: word address, byte enables, level request, one-cycle ack.
interface rom_download_arbiter_if #(
    parameter int ADDR_W = 25
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-2:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [1:0]        mem_be;
    logic              mem_ack;
    logic [15:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/rom_download_arbiter.sv
`timescale 1ns/1ps
// Packs the ioctl byte download into 16-bit ROM writes, otherwise round-robins two word readers.
// Optional: define ROM_DL_CHECKSUM_EN to expose a 16-bit sum of accepted bytes on dl_checksum.
module rom_download_arbiter #(
    parameter int         ADDR_W   = 25,
    parameter logic [7:0] DL_INDEX = 8'h00
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  ioctl_download,
    input  logic [7:0]            ioctl_index,
    input  logic                  ioctl_wr,
    input  logic [ADDR_W-1:0]     ioctl_addr,
    input  logic [7:0]            ioctl_dout,
    output logic                  ioctl_wait,
    input  logic                  rd0_req,
    input  logic                  rd1_req,
    input  logic [ADDR_W-2:0]     rd0_addr,
    input  logic [ADDR_W-2:0]     rd1_addr,
    output logic                  rd0_ack,
    output logic                  rd1_ack,
    output logic [15:0]           rd_data,
    rom_download_arbiter_if.master mem,
    output logic                  dl_done,
    output logic [15:0]           dl_checksum
);
    localparam int WA_W = ADDR_W - 1;

    typedef enum logic [2:0] {IDLE, WR, RD0, RD1, DONE} state_t;
    state_t state_reg, state_next;

    logic            rr_reg, dl_prev_reg;
    logic            lo_valid_reg, lo_valid_next;
    logic [7:0]      lo_data_reg, lo_data_next;
    logic [WA_W-1:0] lo_addr_reg, lo_addr_next;
    logic            wbuf_valid_reg, wbuf_valid_next;
    logic [WA_W-1:0] wbuf_addr_reg, wbuf_addr_next;
    logic [15:0]     wbuf_data_reg, wbuf_data_next;
    logic [1:0]      wbuf_be_reg, wbuf_be_next;
    logic            pend_valid_reg, pend_valid_next;
    logic [WA_W-1:0] pend_addr_reg, pend_addr_next;
    logic [15:0]     pend_data_reg, pend_data_next;
    logic [1:0]      pend_be_reg, pend_be_next;
    logic            end_pending_reg, end_pending_next, dl_done_reg, dl_done_next;
    logic            mem_req_reg, mem_we_reg;
    logic [WA_W-1:0] mem_addr_reg;
    logic [15:0]     mem_wdata_reg;
    logic [1:0]      mem_be_reg;
    logic            rd0_ack_reg, rd1_ack_reg;
    logic [15:0]     rd_data_reg;

    logic            byte_accept, dl_fall, wr_done, lo_match, all_clear, end_active;
    logic [WA_W-1:0] byte_waddr;
    logic [15:0]     flush_data;

    assign byte_accept = ioctl_wr & ioctl_download & (ioctl_index == DL_INDEX) & ~wbuf_valid_reg;
    assign dl_fall     = ~ioctl_download & dl_prev_reg;
    assign wr_done     = (state_reg == WR) & mem.mem_ack;
    assign byte_waddr  = ioctl_addr[ADDR_W-1:1];
    assign lo_match    = lo_valid_reg & (lo_addr_reg == byte_waddr);
    assign flush_data  = {8'h00, lo_data_reg};

    // The pending slot holds the second word when a stale low byte must be flushed first;
    // it moves into the write buffer on the same edge the buffer drains, so ioctl_wait never dips.
    always_comb begin
        lo_valid_next   = lo_valid_reg;
        lo_data_next    = lo_data_reg;
        lo_addr_next    = lo_addr_reg;
        wbuf_valid_next = wbuf_valid_reg;
        wbuf_addr_next  = wbuf_addr_reg;
        wbuf_data_next  = wbuf_data_reg;
        wbuf_be_next    = wbuf_be_reg;
        pend_valid_next = pend_valid_reg;
        pend_addr_next  = pend_addr_reg;
        pend_data_next  = pend_data_reg;
        pend_be_next    = pend_be_reg;

        if (wr_done) begin
            if (pend_valid_reg) begin
                wbuf_addr_next  = pend_addr_reg;
                wbuf_data_next  = pend_data_reg;
                wbuf_be_next    = pend_be_reg;
                pend_valid_next = 1'b0;
            end else begin
                wbuf_valid_next = 1'b0;
            end
        end

        if (byte_accept) begin
            if (!ioctl_addr[0]) begin
                if (lo_valid_reg && !lo_match) begin
                    wbuf_valid_next = 1'b1;
                    wbuf_addr_next  = lo_addr_reg;
                    wbuf_data_next  = flush_data;
                    wbuf_be_next    = 2'b01;
                end
                lo_valid_next = 1'b1;
                lo_data_next  = ioctl_dout;
                lo_addr_next  = byte_waddr;
            end else begin
                wbuf_valid_next = 1'b1;
                lo_valid_next   = 1'b0;
                if (lo_match) begin
                    wbuf_addr_next = byte_waddr;
                    wbuf_data_next = {ioctl_dout, lo_data_reg};
                    wbuf_be_next   = 2'b11;
                end else if (lo_valid_reg) begin
                    wbuf_addr_next  = lo_addr_reg;
                    wbuf_data_next  = flush_data;
                    wbuf_be_next    = 2'b01;
                    pend_valid_next = 1'b1;
                    pend_addr_next  = byte_waddr;
                    pend_data_next  = {ioctl_dout, 8'h00};
                    pend_be_next    = 2'b10;
                end else begin
                    wbuf_addr_next = byte_waddr;
                    wbuf_data_next = {ioctl_dout, 8'h00};
                    wbuf_be_next   = 2'b10;
                end
            end
        end

        if (dl_fall && lo_valid_reg) begin
            lo_valid_next = 1'b0;
            if (wbuf_valid_next) begin
                pend_valid_next = 1'b1;
                pend_addr_next  = lo_addr_reg;
                pend_data_next  = flush_data;
                pend_be_next    = 2'b01;
            end else begin
                wbuf_valid_next = 1'b1;
                wbuf_addr_next  = lo_addr_reg;
                wbuf_data_next  = flush_data;
                wbuf_be_next    = 2'b01;
            end
        end
    end

    assign all_clear        = ~wbuf_valid_next & ~pend_valid_next & ~lo_valid_next;
    assign end_active       = (end_pending_reg | dl_fall) & ~ioctl_download;
    assign dl_done_next     = end_active & all_clear;
    assign end_pending_next = end_active & ~all_clear;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (wbuf_valid_reg)
                    state_next = WR;
                else if (!ioctl_download) begin
                    if (rd0_req && (!rr_reg || !rd1_req))
                        state_next = RD0;
                    else if (rd1_req)
                        state_next = RD1;
                end
            end
            WR:      if (mem.mem_ack) state_next = IDLE;
            RD0,
            RD1:     if (mem.mem_ack) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            rr_reg          <= 1'b0;
            dl_prev_reg     <= 1'b0;
            lo_valid_reg    <= 1'b0;
            lo_data_reg     <= '0;
            lo_addr_reg     <= '0;
            wbuf_valid_reg  <= 1'b0;
            wbuf_addr_reg   <= '0;
            wbuf_data_reg   <= '0;
            wbuf_be_reg     <= '0;
            pend_valid_reg  <= 1'b0;
            pend_addr_reg   <= '0;
            pend_data_reg   <= '0;
            pend_be_reg     <= '0;
            end_pending_reg <= 1'b0;
            dl_done_reg     <= 1'b0;
            mem_req_reg     <= 1'b0;
            mem_we_reg      <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            mem_be_reg      <= '0;
            rd0_ack_reg     <= 1'b0;
            rd1_ack_reg     <= 1'b0;
            rd_data_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            dl_prev_reg     <= ioctl_download;
            lo_valid_reg    <= lo_valid_next;
            lo_data_reg     <= lo_data_next;
            lo_addr_reg     <= lo_addr_next;
            wbuf_valid_reg  <= wbuf_valid_next;
            wbuf_addr_reg   <= wbuf_addr_next;
            wbuf_data_reg   <= wbuf_data_next;
            wbuf_be_reg     <= wbuf_be_next;
            pend_valid_reg  <= pend_valid_next;
            pend_addr_reg   <= pend_addr_next;
            pend_data_reg   <= pend_data_next;
            pend_be_reg     <= pend_be_next;
            end_pending_reg <= end_pending_next;
            dl_done_reg     <= dl_done_next;
            mem_req_reg     <= (state_next == WR) || (state_next == RD0) || (state_next == RD1);
            rd0_ack_reg     <= (state_reg == RD0) && mem.mem_ack;
            rd1_ack_reg     <= (state_reg == RD1) && mem.mem_ack;
            if (((state_reg == RD0) || (state_reg == RD1)) && mem.mem_ack)
                rd_data_reg <= mem.mem_rdata;
            // Bus fields are captured once at grant and held for the whole transaction.
            if (state_reg == IDLE) begin
                case (state_next)
                    WR: begin
                        mem_we_reg    <= 1'b1;
                        mem_addr_reg  <= wbuf_addr_reg;
                        mem_wdata_reg <= wbuf_data_reg;
                        mem_be_reg    <= wbuf_be_reg;
                    end
                    RD0, RD1: begin
                        mem_we_reg    <= 1'b0;
                        mem_addr_reg  <= (state_next == RD0) ? rd0_addr : rd1_addr;
                        mem_wdata_reg <= 16'h0000;
                        mem_be_reg    <= 2'b11;
                        rr_reg        <= (state_next == RD0);
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef ROM_DL_CHECKSUM_EN
    logic [15:0] csum_reg;
    logic        dl_rise;
    assign dl_rise = ioctl_download & ~dl_prev_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            csum_reg <= 16'h0000;
        else if (dl_rise)
            csum_reg <= byte_accept ? {8'h00, ioctl_dout} : 16'h0000;
        else if (byte_accept)
            csum_reg <= csum_reg + {8'h00, ioctl_dout};
    end
    assign dl_checksum = csum_reg;
`else
    assign dl_checksum = 16'h0000;
`endif

    assign ioctl_wait    = wbuf_valid_reg;
    assign dl_done       = dl_done_reg;
    assign rd0_ack       = rd0_ack_reg;
    assign rd1_ack       = rd1_ack_reg;
    assign rd_data       = rd_data_reg;
    assign mem.mem_req   = mem_req_reg;
    assign mem.mem_we    = mem_we_reg;
    assign mem.mem_addr  = mem_addr_reg;
    assign mem.mem_wdata = mem_wdata_reg;
    assign mem.mem_be    = mem_be_reg;
endmodule

// File: tb/tb_rom_download_arbiter.sv
`timescale 1ns/1ps
// Directed bench for rom_download_arbiter: download packing, end flush, index filter, round-robin reads, async reset.
module tb_rom_download_arbiter;
    localparam int ADDR_W = 25;

    logic              clock = 1'b0;
    logic              reset_n = 1'b1;
    logic              ioctl_download = 1'b0;
    logic [7:0]        ioctl_index = 8'h00;
    logic              ioctl_wr = 1'b0;
    logic [ADDR_W-1:0] ioctl_addr = '0;
    logic [7:0]        ioctl_dout = 8'h00;
    logic              ioctl_wait;
    logic              rd0_req = 1'b0, rd1_req = 1'b0;
    logic [ADDR_W-2:0] rd0_addr = '0, rd1_addr = '0;
    logic              rd0_ack, rd1_ack;
    logic [15:0]       rd_data;
    logic              dl_done;
    logic [15:0]       dl_checksum;

    rom_download_arbiter_if #(.ADDR_W(ADDR_W)) mem_if ();

    rom_download_arbiter #(.ADDR_W(ADDR_W), .DL_INDEX(8'h00)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .rd0_req        (rd0_req),
        .rd1_req        (rd1_req),
        .rd0_addr       (rd0_addr),
        .rd1_addr       (rd1_addr),
        .rd0_ack        (rd0_ack),
        .rd1_ack        (rd1_ack),
        .rd_data        (rd_data),
        .mem            (mem_if),
        .dl_done        (dl_done),
        .dl_checksum    (dl_checksum)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

`ifdef ROM_DL_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Memory model: ack mem_lat cycles after mem_req is first seen; read data = addr ^ 5A5A.
    int                mem_lat = 0;
    int                mem_txn = 0;
    logic              log_we = 1'b0;
    logic [ADDR_W-2:0] log_addr = '0;
    logic [15:0]       log_wdata = '0;
    logic [1:0]        log_be = '0;
    int                log_cyc = 0;

    initial begin
        int lat_cnt;
        lat_cnt = 0;
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 16'h0000;
        forever begin
            @(negedge clock);
            if (mem_if.mem_ack) begin
                mem_if.mem_ack = 1'b0;
                lat_cnt = 0;
            end else if (mem_if.mem_req) begin
                if (lat_cnt >= mem_lat) begin
                    mem_if.mem_ack   = 1'b1;
                    mem_if.mem_rdata = mem_if.mem_addr[15:0] ^ 16'h5A5A;
                    log_we    = mem_if.mem_we;
                    log_addr  = mem_if.mem_addr;
                    log_wdata = mem_if.mem_wdata;
                    log_be    = mem_if.mem_be;
                    log_cyc   = cyc;
                    mem_txn++;
                    lat_cnt = 0;
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic send_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d, input logic [7:0] idx);
        int n;
        n = 0;
        while (ioctl_wait && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check_val("send_wait_timeout", 32'd1, 32'd0);
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        tick();
        ioctl_wr    = 1'b0;
    endtask

    task automatic wait_done(output int done_cnt, output int done_cyc);
        done_cnt = 0;
        done_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dl_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    endtask

    initial begin
        int done_cnt, done_cyc, txn0, req_cnt, wait_cnt, n_ack, wide, found;
        int seq[3];
        int rdat[3];
        int lat_ok[3];
        logic prev_ack;

        reset_n = 1'b0;
        tick();
        tick();
        check_val("reset_mem_req", mem_if.mem_req, 0);
        check_val("reset_wait", ioctl_wait, 0);
        check_val("reset_dl_done", dl_done, 0);
        check_val("reset_acks", {rd0_ack, rd1_ack}, 0);
        check_val("reset_rd_data", rd_data, 0);
        check_val("reset_checksum", dl_checksum, 0);
        reset_n = 1'b1;
        tick();
        tick();

        // Two-byte download, zero-wait memory
        ioctl_download = 1'b1;
        tick();
        send_byte(25'd0, 8'h12, 8'h00);
        send_byte(25'd1, 8'h34, 8'h00);
        check_val("t1_wait_after_form", ioctl_wait, 1);
        check_val("t1_no_req_yet", mem_if.mem_req, 0);
        tick();
        check_val("t1_mem_req", mem_if.mem_req, 1);
        check_val("t1_wait_during_wr", ioctl_wait, 1);
        check_val("t1_we", mem_if.mem_we, 1);
        check_val("t1_addr", mem_if.mem_addr, 0);
        check_val("t1_wdata", mem_if.mem_wdata, 16'h3412);
        check_val("t1_be", mem_if.mem_be, 2'b11);
        tick();
        check_val("t1_wait_cleared", ioctl_wait, 0);
        check_val("t1_req_dropped", mem_if.mem_req, 0);
        ioctl_download = 1'b0;
        tick();
        check_val("t1_dl_done", dl_done, 1);
        tick();
        check_val("t1_dl_done_1cyc", dl_done, 0);
        check_val("t1_checksum", dl_checksum, CSUM_ON ? 16'h0046 : 16'h0000);

        // Odd-length download with end-of-download flush
        ioctl_download = 1'b1;
        tick();
        txn0 = mem_txn;
        send_byte(25'd0, 8'hAA, 8'h00);
        send_byte(25'd1, 8'hBB, 8'h00);
        send_byte(25'd2, 8'hCC, 8'h00);
        ioctl_download = 1'b0;
        wait_done(done_cnt, done_cyc);
        check_val("t2_write_count", mem_txn - txn0, 2);
        check_val("t2_we", log_we, 1);
        check_val("t2_addr", log_addr, 1);
        check_val("t2_wdata", log_wdata, 16'h00CC);
        check_val("t2_be", log_be, 2'b01);
        check_val("t2_done_pulses", done_cnt, 1);
        check_val("t2_done_after_ack", done_cyc, log_cyc + 1);
        check_val("t2_checksum", dl_checksum, CSUM_ON ? 16'h0231 : 16'h0000);

        // Foreign index is ignored; checksum of FF,FF,02
        ioctl_download = 1'b1;
        tick();
        send_byte(25'd0, 8'hFF, 8'h00);
        send_byte(25'd1, 8'hFF, 8'h00);
        send_byte(25'd3, 8'h77, 8'h01);
        txn0 = mem_txn;
        req_cnt = 0;
        wait_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mem_if.mem_req) req_cnt++;
            if (ioctl_wait) wait_cnt++;
        end
        check_val("t3_foreign_no_req", req_cnt, 0);
        check_val("t3_foreign_no_wait", wait_cnt, 0);
        check_val("t3_foreign_no_txn", mem_txn - txn0, 0);
        check_val("t3_checksum_unchanged", dl_checksum, CSUM_ON ? 16'h01FE : 16'h0000);
        send_byte(25'd2, 8'h02, 8'h00);
        ioctl_download = 1'b0;
        wait_done(done_cnt, done_cyc);
        check_val("t6_flush_addr", log_addr, 1);
        check_val("t6_flush_wdata", log_wdata, 16'h0002);
        check_val("t6_flush_be", log_be, 2'b01);
        check_val("t6_done_pulses", done_cnt, 1);
        check_val("t6_checksum", dl_checksum, CSUM_ON ? 16'h0200 : 16'h0000);

        // Round-robin reads, both requesters held, 2-cycle memory
        mem_lat  = 2;
        rd0_addr = 24'h000100;
        rd1_addr = 24'h000200;
        rd0_req  = 1'b1;
        rd1_req  = 1'b1;
        n_ack = 0;
        wide = 0;
        prev_ack = 1'b0;
        for (int i = 0; i < 60 && n_ack < 3; i++) begin
            tick();
            if (rd0_ack && rd1_ack) wide++;
            if ((rd0_ack || rd1_ack) && prev_ack) wide++;
            if (rd0_ack || rd1_ack) begin
                seq[n_ack]    = rd1_ack ? 1 : 0;
                rdat[n_ack]   = int'(rd_data);
                lat_ok[n_ack] = (cyc == log_cyc + 1) ? 1 : 0;
                n_ack++;
            end
            prev_ack = rd0_ack | rd1_ack;
        end
        rd0_req = 1'b0;
        rd1_req = 1'b0;
        check_val("t4_ack_count", n_ack, 3);
        if (n_ack == 3) begin
            check_val("t4_grant0_rd0", seq[0], 0);
            check_val("t4_grant1_rd1", seq[1], 1);
            check_val("t4_grant2_rd0", seq[2], 0);
            check_val("t4_data0", rdat[0], 32'h5B5A);
            check_val("t4_data1", rdat[1], 32'h585A);
            check_val("t4_data2", rdat[2], 32'h5B5A);
            check_val("t4_ack_latency", lat_ok[0] + lat_ok[1] + lat_ok[2], 3);
        end
        check_val("t4_ack_single_cycle", wide, 0);
        for (int i = 0; i < 10; i++) tick();

        // Reset asserted while a write is outstanding
        mem_lat = 10;
        ioctl_download = 1'b1;
        tick();
        send_byte(25'd4, 8'h11, 8'h00);
        send_byte(25'd5, 8'h22, 8'h00);
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            tick();
            if (mem_if.mem_req && mem_if.mem_we) found = 1;
        end
        check_val("t5_write_started", found, 1);
        reset_n = 1'b0;
        #1;
        check_val("t5_async_mem_req", mem_if.mem_req, 0);
        check_val("t5_async_wait", ioctl_wait, 0);
        check_val("t5_async_dl_done", dl_done, 0);
        ioctl_download = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        req_cnt = 0;
        wait_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (mem_if.mem_req) req_cnt++;
            if (ioctl_wait) wait_cnt++;
            if (dl_done) done_cnt++;
        end
        check_val("t5_idle_no_req", req_cnt, 0);
        check_val("t5_idle_no_wait", wait_cnt, 0);
        check_val("t5_idle_no_done", done_cnt, 0);
        check_val("t5_checksum_cleared", dl_checksum, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
